// File: rtl/dfh_walker_pkg.sv
// Shared types and constants for the DFH chain walker.
//   t_dfh       : field layout of a 64-bit Device Feature Header
//   t_tbl_entry : 48-bit feature table record
//   ERR_*       : err_code values
//   t_state     : walker FSM states
package dfh_walker_pkg;

    localparam int unsigned DFH_W   = 64;
    localparam int unsigned ENTRY_W = 48;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [7:0]  rsvd1;
        logic [3:0]  minor;
        logic [6:0]  rsvd0;
        logic        eol;
        logic [23:0] next_off;
        logic [3:0]  major;
        logic [11:0] feat_id;
    } t_dfh;

    typedef struct packed {
        logic [23:0] addr;
        logic [3:0]  feat_type;
        logic [3:0]  minor;
        logic [3:0]  major;
        logic [11:0] feat_id;
    } t_tbl_entry;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
    localparam logic [2:0] ERR_RSP      = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_ADDR     = 3'd4;
    localparam logic [2:0] ERR_MISALIGN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DECODE,
        S_DONE,
        S_ERR
    } t_state;

endpackage

// File: rtl/dfh_walker_if.sv
// MMIO read path between the walker (master) and the BAR0 read port (slave).
//   rd_req_valid/rd_req_ready/rd_req_addr : 64-bit read request handshake
//   rd_rsp_valid/rd_rsp_data/rd_rsp_err   : one response per accepted request
interface dfh_walker_if #(
    parameter int unsigned ADDR_W = 20
) ();
    import dfh_walker_pkg::*;

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid;
    logic [DFH_W-1:0]  rd_rsp_data;
    logic              rd_rsp_err;

    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
    );

endinterface

// File: rtl/dfh_walker_tbl.sv
// Feature table: DEPTH x 48-bit register file, one write port, registered read.
//   clk, rst_n  : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, data valid one cycle after raddr
module dfh_walker_tbl
    import dfh_walker_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  t_tbl_entry               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    // Contents are don't-care after reset, so the array has no reset.
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dfh_walker_ctrl.sv
// DFH chain walker: reads Device Feature Headers over MMIO starting at
// start_addr, records each feature in a table and follows next_off until
// EOL, a zero offset or an error.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, start_addr   : walk request (honoured in IDLE/DONE/ERR)
//   mmio                : MMIO read request/response (master side)
//   busy, done, err     : walk status levels; err_code qualifies err
//   feat_cnt            : number of valid table entries
//   tbl_idx, tbl_data   : table read port, 1-cycle latency
module dfh_walker_ctrl
    import dfh_walker_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned MAX_FEAT    = 16,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             start_addr,
    dfh_walker_if.master                  mmio,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    err_code,
    output logic [$clog2(MAX_FEAT+1)-1:0] feat_cnt,
    input  logic [$clog2(MAX_FEAT)-1:0]   tbl_idx,
    output logic [ENTRY_W-1:0]            tbl_data
);

    localparam int unsigned CNT_W = $clog2(MAX_FEAT + 1);
    localparam int unsigned IDX_W = $clog2(MAX_FEAT);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_FEAT);

    t_state            state;
    t_state            next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic              req_valid;
    logic [TMO_W-1:0]  tmo_cnt;
    t_dfh              dfh_q;
    logic [2:0]        code_d;

    logic              valid_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic              load_start;
    logic              accept;
    logic              rsp_take;
    logic              tbl_we;
    logic              addr_step;

    // Decode of the registered DFH.
    logic              full;
    logic              chain_end;
    logic              off_misal;
    logic              addr_ovf;
    logic [ADDR_W:0]   nxt_sum;
    t_tbl_entry        wr_entry;
    logic              unused_rsvd;

    assign full      = (feat_cnt == CNT_FULL);
    assign chain_end = dfh_q.eol || (dfh_q.next_off == '0);
    assign off_misal = (dfh_q.next_off[2:0] != 3'd0);
    assign nxt_sum   = {1'b0, cur_addr} + {1'b0, dfh_q.next_off[ADDR_W-1:0]};
    // Offset bits above ADDR_W, or a carry out, leave the BAR window.
    assign addr_ovf  = nxt_sum[ADDR_W] || ((dfh_q.next_off >> ADDR_W) != 24'd0);

    assign wr_entry = '{
        addr:      24'(cur_addr),
        feat_type: dfh_q.feat_type,
        minor:     dfh_q.minor,
        major:     dfh_q.major,
        feat_id:   dfh_q.feat_id
    };
    assign unused_rsvd = ^{dfh_q.rsvd1, dfh_q.rsvd0};

    assign mmio.rd_req_valid = req_valid;
    assign mmio.rd_req_addr  = cur_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and error-code selection.
    always_comb begin
        next_state = state;
        code_d     = err_code;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (start_addr[2:0] != 3'd0) begin
                        next_state = S_ERR;
                        code_d     = ERR_MISALIGN;
                    end else begin
                        next_state = S_ISSUE;
                        code_d     = ERR_NONE;
                    end
                end
            end
            S_ISSUE: begin
                if (mmio.rd_req_ready) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the terminal count still wins.
                if (mmio.rd_rsp_valid) begin
                    if (mmio.rd_rsp_err) begin
                        next_state = S_ERR;
                        code_d     = ERR_RSP;
                    end else begin
                        next_state = S_DECODE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state = S_ERR;
                    code_d     = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (full) begin
                    next_state = S_ERR;
                    code_d     = ERR_OVERFLOW;
                end else if (chain_end) begin
                    next_state = S_DONE;
                end else if (off_misal) begin
                    next_state = S_ERR;
                    code_d     = ERR_MISALIGN;
                end else if (addr_ovf) begin
                    next_state = S_ERR;
                    code_d     = ERR_ADDR;
                end else begin
                    next_state = S_ISSUE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output and datapath strobes; status outputs follow next_state so they
    // are registered and line up with the state they describe.
    always_comb begin
        load_start = 1'b0;
        accept     = 1'b0;
        rsp_take   = 1'b0;
        tbl_we     = 1'b0;
        addr_step  = 1'b0;
        valid_d    = (next_state == S_ISSUE);
        busy_d     = next_state inside {S_ISSUE, S_WAIT, S_DECODE};
        done_d     = (next_state == S_DONE);
        err_d      = (next_state == S_ERR);
        case (state)
            S_IDLE, S_DONE, S_ERR: load_start = start;
            S_ISSUE:               accept     = mmio.rd_req_ready;
            S_WAIT:                rsp_take   = mmio.rd_rsp_valid && !mmio.rd_rsp_err;
            S_DECODE: begin
                tbl_we    = !full;
                addr_step = (next_state == S_ISSUE);
            end
            default: ;
        endcase
    end

    // Registered outputs and walk datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            feat_cnt  <= '0;
            cur_addr  <= '0;
            tmo_cnt   <= '0;
            dfh_q     <= '0;
        end else begin
            req_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            err_code  <= code_d;
            if (load_start) begin
                cur_addr <= start_addr;
                feat_cnt <= '0;
            end else begin
                if (addr_step) begin
                    cur_addr <= nxt_sum[ADDR_W-1:0];
                end
                if (tbl_we) begin
                    feat_cnt <= feat_cnt + CNT_W'(1);
                end
            end
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (rsp_take) begin
                dfh_q <= mmio.rd_rsp_data;
            end
        end
    end

    dfh_walker_tbl #(
        .DEPTH (MAX_FEAT)
    ) u_tbl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (IDX_W'(feat_cnt)),
        .wdata (wr_entry),
        .raddr (tbl_idx),
        .rdata (tbl_data)
    );

endmodule

// File: doc/dfh_walker_ctrl.md
# dfh_walker_ctrl

Hardware DFH chain walker for the SoC-side feature list. On `start` it issues 64-bit MMIO reads beginning at a programmable BAR offset. Each returned Device Feature Header is decoded, and its feature ID, type, major/minor version and address are recorded in an internal table. The walk follows the next-DFH offset until EOL, a zero offset, or an error. It sits between the management/test sequencer and the BAR0 MMIO read path (FME, PMCI, HSSI, EMIF, QSFP, ST2MM, port-gasket features), and replaces software polling during bring-up and self-test.

## Interface
Parameters:
- `ADDR_W`, 20, byte-address width of the MMIO read path.
- `MAX_FEAT`, 16, table depth (number of DFHs recorded).
- `TIMEOUT_CYC`, 256, maximum cycles allowed from request acceptance to response.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle pulse; honoured only in IDLE, DONE or ERR.
- `start_addr` in ADDR_W: first DFH byte address; sampled with `start`.
- `rd_req_valid` out 1 / `rd_req_ready` in 1 / `rd_req_addr` out ADDR_W: 64-bit read request; valid/ready handshake.
- `rd_rsp_valid` in 1 / `rd_rsp_data` in 64 / `rd_rsp_err` in 1: read response, one per request.
- `busy` out 1: walk in progress.
- `done` out 1: level; the walk ended without error.
- `err` out 1 / `err_code` out 3: level; 1=timeout, 2=response error, 3=table overflow, 4=address overflow, 5=misaligned next offset.
- `feat_cnt` out $clog2(MAX_FEAT+1): number of valid table entries.
- `tbl_idx` in $clog2(MAX_FEAT) / `tbl_data` out 48: table read port with 1-cycle latency. Packing: {addr[ADDR_W-1:0] zero-extended to 24, feat_type[3:0], minor[3:0], major[3:0], feat_id[11:0]}.

## Operation
DFH decode, taking the 64-bit word as `d`:
- feat_id = d[11:0]
- major = d[15:12]
- next_off = d[39:16]
- eol = d[40]
- minor = d[51:48]
- feat_type = d[63:60]

FSM states: IDLE, ISSUE, WAIT, DECODE, DONE, ERR.
- IDLE/DONE/ERR + `start`: latch `cur_addr=start_addr`, clear `feat_cnt`, `done`, `err`; go to ISSUE. If `start_addr[2:0]!=0`, go to ERR with code 5.
- ISSUE: drive `rd_req_valid=1`, `rd_req_addr=cur_addr`. When `rd_req_ready` is high, go to WAIT and clear the timeout counter.
- WAIT: the timeout counter increments each cycle.
  - `rd_rsp_valid & rd_rsp_err`: go to ERR, code 2.
  - `rd_rsp_valid` without error: register the data; go to DECODE.
  - Counter reaches TIMEOUT_CYC-1 with no response: go to ERR, code 1.
- DECODE: decode the registered DFH.
  - If `feat_cnt==MAX_FEAT`: go to ERR, code 3. The entry is not written.
  - Otherwise write the entry at index `feat_cnt` and increment `feat_cnt`.
  - Then: if `eol` or `next_off==0`, go to DONE.
  - Else if `next_off[2:0]!=0`, go to ERR, code 5.
  - Else compute `nxt = cur_addr + next_off` using ADDR_W+1 bits. If the carry is set or `next_off[23:ADDR_W]` is nonzero, go to ERR, code 4. Otherwise set `cur_addr=nxt` and go to ISSUE.
- DONE/ERR are sticky until the next `start` or reset. The table remains readable in both states.
- A `start` pulse while `busy` is ignored.
- A response that arrives while not in WAIT is dropped.

## Timing
- Reset values: `rd_req_valid=0`, `rd_req_addr=0`, `busy=0`, `done=0`, `err=0`, `err_code=0`, `feat_cnt=0`, `tbl_data=0`. FSM resets to IDLE. Table contents are don't-care.
- `busy` goes high the cycle after an accepted `start` and is high in ISSUE, WAIT and DECODE.
- Per-feature cost: 1 (ISSUE) + request stall + response latency + 1 (DECODE).
- `rd_req_valid` and `rd_req_addr` are registered and stay stable until ready.
- A response on the same cycle as the timeout terminal count wins; no error is raised.
- `done`/`err` assert the cycle after DECODE or WAIT resolves.
- Reset asserted mid-walk aborts immediately and drops any outstanding response. Exactly one request is outstanding at any time.

## Structure
- Package `dfh_walker_pkg` holds:
  - the `t_dfh` packed struct and the table-entry struct;
  - the err_code localparams (ERR_TIMEOUT … ERR_MISALIGN);
  - the FSM state enum.
- Sub-module `dfh_walker_tbl`: MAX_FEAT×48 register-file table with one write port and a registered read port.

## Test plan
- Chain of 3 DFHs at 0x0, 0x1000, 0x3000. Offsets 0x1000 and 0x2000; the third has eol=1. Zero-latency responder. → `done=1`, `feat_cnt=3`, `tbl_idx=1` returns addr 0x1000.
- DFH `64'h3_00000_000000_1004` (next_off=0) → `done` after 1 entry; entry feat_id 0x004, major 1, type 3.
- Responder never answers, TIMEOUT_CYC=256 → `err=1`, `err_code=1` exactly 256 cycles after request acceptance. Then pulse `start` again with a working responder → normal completion.
- `rd_rsp_err=1` on the 2nd read → `err_code=2`, `feat_cnt=1`.
- Circular chain (next_off=0x1000 wrapping past ADDR_W) → `err_code=4`. Self-loop chain with MAX_FEAT=16 → `err_code=3`, `feat_cnt=16`.
- Random `rd_req_ready` stalls and `rst_n` dropped mid-WAIT → after reset all outputs are zero, no request is re-issued, and a late response is ignored.
